serial_encoder: RTL



---
 rtl/serial_encoder.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/serial_encoder.sv
// Parallel-in/serial-out encoder: valid/ready word intake, one-word holding register, LSB-first shifting.
// Optional macro ENCODER_PARITY_EN appends an even-parity bit cycle after each data frame.
module serial_encoder #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] parallelIn,
    input  logic             inValid,
    output logic             inReady,
    output logic             serialOut,
    output logic             frameStart,
    output logic             busy
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

`ifdef ENCODER_PARITY_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] w_shift_next;
    logic [CW-1:0]    r_bit_cnt;
    logic [CW-1:0]    w_bit_cnt_next;
    logic [WIDTH-1:0] r_hold;
    logic [WIDTH-1:0] w_hold_next;
    logic             r_hold_full;
    logic             w_hold_full_next;
    logic             w_accept;
    logic             w_last_bit;
    logic             w_frame_end;
`ifdef ENCODER_PARITY_EN
    logic             r_parity;
    logic             w_parity_next;
`endif

    assign w_accept   = inValid && !r_hold_full;
    assign w_last_bit = (r_state == SHIFT) && (r_bit_cnt == LAST_BIT);

`ifdef ENCODER_PARITY_EN
    assign w_frame_end = (r_state == IDLE) || (r_state == PARITY);
`else
    assign w_frame_end = (r_state == IDLE) || w_last_bit;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_shift     <= w_shift_next;
            r_bit_cnt   <= w_bit_cnt_next;
            r_hold      <= w_hold_next;
            r_hold_full <= w_hold_full_next;
        end
    end

`ifdef ENCODER_PARITY_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            r_parity <= 1'b0;
        end else begin
            r_parity <= w_parity_next;
        end
    end
`endif

    always_comb begin
        w_state_next     = r_state;
        w_shift_next     = r_shift;
        w_bit_cnt_next   = r_bit_cnt;
        w_hold_next      = r_hold;
        w_hold_full_next = r_hold_full;
`ifdef ENCODER_PARITY_EN
        w_parity_next    = r_parity;
`endif
        if (w_frame_end) begin
            // A full hold always wins; inReady is low then, so no accept can collide.
            if (r_hold_full) begin
                w_shift_next     = r_hold;
                w_hold_full_next = 1'b0;
                w_state_next     = SHIFT;
                w_bit_cnt_next   = '0;
`ifdef ENCODER_PARITY_EN
                w_parity_next    = ^r_hold;
`endif
            end else if (w_accept) begin
                w_shift_next   = parallelIn;
                w_state_next   = SHIFT;
                w_bit_cnt_next = '0;
`ifdef ENCODER_PARITY_EN
                w_parity_next  = ^parallelIn;
`endif
            end else begin
                w_state_next = IDLE;
            end
        end else begin
            if (w_accept) begin
                w_hold_next      = parallelIn;
                w_hold_full_next = 1'b1;
            end
            if (r_state == SHIFT) begin
                w_shift_next = r_shift >> 1;
                if (!w_last_bit) begin
                    w_bit_cnt_next = r_bit_cnt + 1'b1;
                end
`ifdef ENCODER_PARITY_EN
                else begin
                    w_state_next = PARITY;
                end
`endif
            end
        end
    end

    always_comb begin
        serialOut = 1'b0;
        if (r_state == SHIFT) begin
            serialOut = r_shift[0];
        end
`ifdef ENCODER_PARITY_EN
        else if (r_state == PARITY) begin
            serialOut = r_parity;
        end
`endif
    end

    assign frameStart = (r_state == SHIFT) && (r_bit_cnt == '0);
    assign busy       = (r_state != IDLE);
    assign inReady    = !r_hold_full;

endmodule
